// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM: byte-lane writes, registered read with valid strobe, and an
// init engine that fills word k with INIT_BASE + k after reset. RAM_SP_PARITY_EN adds byte parity.
module ram_sp_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned INIT_BASE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef RAM_SP_PARITY_EN
  input  logic                  i_par_inject,
  output logic                  o_par_err,
`endif
  input  logic                  i_cs,
  input  logic                  i_rw,
  input  logic [ADDR_W-1:0]     i_address,
  input  logic [DATA_W/8-1:0]   i_byte_en,
  input  logic [DATA_W-1:0]     i_data_in,
  output logic [DATA_W-1:0]     o_data_out,
  output logic                  o_rd_valid,
  output logic                  o_busy
);

  localparam int NumBytes = DATA_W / 8;
  localparam int Depth    = 2 ** ADDR_W;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_rd_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [Depth];

  logic                w_accept;
  logic                w_init_wr;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;

  assign w_accept  = (r_state == StIdle) && i_cs;
  assign w_init_wr = (r_state == StInit) && !i_rst;
  assign w_rdata   = r_mem[i_address];

  // Partial writes merge the enabled lanes into the currently stored word.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = i_address;
    w_wdata = w_rdata;
    if (w_init_wr) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = DATA_W'(INIT_BASE) + DATA_W'(r_cnt);
    end else if (!i_rst && w_accept && !i_rw) begin
      w_we = |i_byte_en;
      for (int b = 0; b < NumBytes; b++) begin
        if (i_byte_en[b]) w_wdata[8*b +: 8] = i_data_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

`ifdef RAM_SP_PARITY_EN
  logic [NumBytes-1:0] r_par [Depth];
  logic [NumBytes-1:0] w_wpar;
  logic [NumBytes-1:0] w_rd_calc;
  logic                r_par_err;

  // Injection flips only the lanes written by a normal access, never init writes.
  always_comb begin
    w_wpar = r_par[i_address];
    for (int b = 0; b < NumBytes; b++) begin
      w_rd_calc[b] = ^w_rdata[8*b +: 8];
      if (w_init_wr || i_byte_en[b]) begin
        w_wpar[b] = (^w_wdata[8*b +: 8]) ^ (!w_init_wr && i_par_inject);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_par[w_waddr] <= w_wpar;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_accept && i_rw && (|(w_rd_calc ^ r_par[i_address]));
    end
  end

  assign o_par_err = r_par_err;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StInit;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        StInit: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (&r_cnt) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StIdle: begin
          if (w_accept && i_rw) begin
            r_data_out <= w_rdata;
            r_rd_valid <= 1'b1;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign o_data_out = r_data_out;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param (default parameters); reads push expected data and cycle into a
// scoreboard that a negedge monitor drains whenever rd_valid is seen.
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        rw;
  logic [3:0]  address;
  logic [1:0]  byte_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        busy;
`ifdef RAM_SP_PARITY_EN
  logic        par_inject;
  logic        par_err;
`endif

  typedef struct {
    logic [15:0] data;
    logic        perr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;

  ram_sp_param #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .INIT_BASE (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef RAM_SP_PARITY_EN
    .i_par_inject (par_inject),
    .o_par_err    (par_err),
`endif
    .i_cs       (cs),
    .i_rw       (rw),
    .i_address  (address),
    .i_byte_en  (byte_en),
    .i_data_in  (data_in),
    .o_data_out (data_out),
    .o_rd_valid (rd_valid),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected read, on the expected cycle.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb_q.size() == 0) begin
        n_check++;
        $display("FAIL unexpected_rd_valid: got data %h at cycle %0d, expected no pulse",
                 data_out, cyc);
      end else begin
        exp_t e;
        logic ok;
        e  = sb_q.pop_front();
        ok = (data_out === e.data) && (cyc == e.cyc);
`ifdef RAM_SP_PARITY_EN
        ok = ok && (par_err === e.perr);
`endif
        n_check++;
        if (ok) n_pass++;
        else $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d",
                      data_out, cyc, e.data, e.cyc);
      end
    end
  end

  // Tasks start and end at posedge+1; the access is accepted on the next posedge.
  task automatic wr(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d,
                    input logic inj = 1'b0);
    cs = 1'b1; rw = 1'b0; address = a; byte_en = be; data_in = d;
`ifdef RAM_SP_PARITY_EN
    par_inject = inj;
`else
    if (inj) $display("parity injection ignored in this build");
`endif
    @(posedge clk); #1;
    cs = 1'b0;
`ifdef RAM_SP_PARITY_EN
    par_inject = 1'b0;
`endif
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input logic perr = 1'b0);
    exp_t e;
    cs = 1'b1; rw = 1'b1; address = a;
    e.data = exp; e.perr = perr; e.cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b0; address = '0; byte_en = '0; data_in = '0;
`ifdef RAM_SP_PARITY_EN
    par_inject = 1'b0;
`endif
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_data_out", {16'd0, data_out}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;

    // Init takes 16 edges; a write attempted during init must be ignored.
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        cs = 1'b1; rw = 1'b0; address = 4'd3; byte_en = 2'b11; data_in = 16'hFFFF;
      end else begin
        cs = 1'b0;
      end
      chk($sformatf("init_busy_%0d", i), {31'd0, busy}, (i < 16) ? 32'd1 : 32'd0);
      chk($sformatf("init_rd_valid_%0d", i), {31'd0, rd_valid}, 32'd0);
    end

    rd(4'd0, 16'h0001);
    rd(4'd15, 16'h0010);
    rd(4'd3, 16'h0004);

    wr(4'd5, 2'b10, 16'hAB12);
    rd(4'd5, 16'hAB06);
    wr(4'd5, 2'b01, 16'h0077);
    rd(4'd5, 16'hAB77);
    wr(4'd5, 2'b00, 16'hFFFF);
    rd(4'd5, 16'hAB77);

    wr(4'd9, 2'b11, 16'h1234);
    rd(4'd9, 16'h1234);
    wr(4'd15, 2'b11, 16'hBEEF);
    rd(4'd15, 16'hBEEF);
    idle(3);
    chk("data_out_hold", {16'd0, data_out}, 32'h0000BEEF);
    chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);

`ifdef RAM_SP_PARITY_EN
    wr(4'd2, 2'b01, 16'h00A5, 1'b1);
    rd(4'd2, 16'h00A5, 1'b1);
    wr(4'd2, 2'b11, 16'h5A5A);
    rd(4'd2, 16'h5A5A, 1'b0);
    idle(2);
`endif

    // Reset from idle clears data_out immediately, then again 7 cycles into init.
    rst = 1'b1; #1;
    chk("rst_idle_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_idle_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(7);
    chk("mid_init_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_init_busy", {31'd0, busy}, 32'd1);
    chk("rst_mid_init_data_out", {16'd0, data_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(15);
    chk("reinit_busy_15", {31'd0, busy}, 32'd1);
    idle(1);
    chk("reinit_busy_16", {31'd0, busy}, 32'd0);
    rd(4'd7, 16'h0008);
    rd(4'd5, 16'h0006);
    rd(4'd9, 16'h000A);
    idle(3);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM for the RISC processor datapath; successor to the fixed 16x16 data memory.
- Width and depth are generic. Adds byte-lane write enables, a registered read with a valid strobe, and a sequential init engine.
- The init engine loads a deterministic pattern after reset, so the memory is usable without a testbench preload.
- Sits between the processor's load/store unit and the data bus.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- INIT_BASE, 1, value written to word 0 during init; word k gets INIT_BASE + k, truncated to DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  chip select; access is accepted only when cs=1 and busy=0.
- rw  input  1  1 = read, 0 = write.
- address  input  ADDR_W  word address.
- byte_en  input  DATA_W/8  per-byte write enable; bit i gates data_in[8i+7:8i].
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; data_out was updated this cycle.
- busy  output  1  high while the init engine runs.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - data_out = 0, rd_valid = 0, busy = 1.
  - State = INIT, init counter = 0.
  - Memory contents are not reset asynchronously.
- INIT state:
  - Each cycle after rst deasserts, write mem[cnt] = INIT_BASE + cnt, then cnt++.
  - After writing index 2**ADDR_W-1, go to IDLE; busy falls on the same edge.
  - Init therefore takes exactly 2**ADDR_W cycles.
  - cs is ignored during INIT. No writes or reads are accepted and rd_valid stays 0.
- IDLE state, cs=1, rw=1 (read):
  - data_out <= mem[address] on the accepting edge; rd_valid=1 for that one cycle.
  - Latency is 1 cycle.
  - data_out holds its value until the next accepted read.
- IDLE state, cs=1, rw=0 (write):
  - For each i with byte_en[i]=1, mem[address] byte i <= data_in byte i. Other bytes are unchanged.
  - byte_en all zero is a no-op. rd_valid=0 and data_out is unchanged.
- IDLE state, cs=0: no state change, rd_valid=0.
- Read-after-write to the same address on consecutive cycles returns the newly written data (no bypass is needed; the write lands first).
- Address wraps naturally; no out-of-range condition exists.
- Reset asserted mid-operation, including mid-INIT:
  - Immediately forces the reset values above.
  - Init restarts from index 0 after release.
  - Any partially completed init is overwritten.
- There are no X-propagating paths: every branch assigns its outputs or holds them.

Optional Feature:
- Macro RAM_SP_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit per byte, computed on write (including init writes) from the merged stored byte.
  - Adds output port par_err (1 bit, reset 0). It pulses with rd_valid if any byte's stored parity mismatches its data on read.
  - Adds input port par_inject (1 bit). When 1 during a write, the stored parity of every enabled byte is inverted, for test only.
- Not defined: no parity storage, ports par_err and par_inject are absent, and behaviour is as above.

Test Plan:
- Reset then wait: busy stays high 16 cycles (default params) then falls. Reading addr 0 and addr 15 returns 16'h0001 and 16'h0010, each with a rd_valid pulse one cycle later.
- Access during init: cs=1, rw=0, addr 3, data 16'hFFFF at cycle 2 after reset release. After init, reading addr 3 returns 16'h0004 (write ignored), and rd_valid stayed 0 throughout init.
- Byte write: addr 5, byte_en=2'b10, data_in=16'hAB12 → read returns 16'hAB06. Then byte_en=2'b01, data 16'h0077 → read returns 16'hAB77. byte_en=2'b00 → unchanged.
- Back-to-back: write 16'h1234 to addr 9, read addr 9 next cycle → data_out=16'h1234 with rd_valid one cycle after the read.
- Reset mid-init: assert rst at init cycle 7 → busy stays 1, data_out=0 immediately. After release, a full 16-cycle init completes and addr 7 reads 16'h0008.
- Parametrisation plus parity (DATA_W=32, ADDR_W=3, RAM_SP_PARITY_EN): init lasts 8 cycles.
  - Write addr 2 with par_inject=1 and byte_en=4'b0100, then read → par_err=1.
  - Clean write then read → par_err=0.
